// File: rtl/ready_valid_counter_pkg.sv
// Shared control-path FSM encoding for the single-shot cycle counter.
package ready_valid_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } rvc_state_e;

endpackage

// File: rtl/ready_valid_counter.sv
// Single-shot counter: go accepted in IDLE, counts 0..MAX_VAL, then one-cycle done; done MAX_VAL+2 cycles after accept.
// Backpressure: ready is low for the whole run, and go is simply dropped (never queued) while busy.
module ready_valid_counter
    import ready_valid_counter_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MAX_VAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output logic             ready,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    if ((MAX_VAL < 0) || (MAX_VAL > (2 ** WIDTH) - 1)) begin : g_bad_max_val
        $error("ready_valid_counter: MAX_VAL %0d does not fit in WIDTH %0d", MAX_VAL, WIDTH);
    end

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    rvc_state_e       state;
    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (go) begin
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    // Stop at the terminal value so the register can never wrap.
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // All outputs decode registered state only: no path from go.
    assign ready = (state == ST_IDLE);
    assign done  = (state == ST_DONE);
    assign count = cnt;

endmodule

// File: tb/tb_ready_valid_counter.sv
// Scoreboard bench for ready_valid_counter: default, 4-bit/15 and 1-bit/0 instances.
module tb_ready_valid_counter;

    typedef struct packed {
        logic       ready;
        logic [3:0] count;
        logic       done;
    } exp_t;

    localparam exp_t IDLE_E = '{ready: 1'b1, count: 4'd0, done: 1'b0};

    logic clk = 1'b0;
    logic rst;
    logic go0, go1, go2;
    logic       rdy0, rdy1, rdy2;
    logic [1:0] cnt0;
    logic [3:0] cnt1;
    logic [0:0] cnt2;
    logic       dn0, dn1, dn2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    ready_valid_counter dut_def (
        .clk(clk), .rst(rst), .go(go0), .ready(rdy0), .count(cnt0), .done(dn0)
    );

    ready_valid_counter #(.WIDTH(4), .MAX_VAL(15)) dut_w4 (
        .clk(clk), .rst(rst), .go(go1), .ready(rdy1), .count(cnt1), .done(dn1)
    );

    ready_valid_counter #(.WIDTH(1), .MAX_VAL(0)) dut_m0 (
        .clk(clk), .rst(rst), .go(go2), .ready(rdy2), .count(cnt2), .done(dn2)
    );

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual == required) passed++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, actual, required);
    endtask

    // Monitor: the DUTs present ready/count/done every cycle; compare against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("def.ready", int'(rdy0), int'(e.ready));
            check("def.count", int'(cnt0), int'(e.count));
            check("def.done",  int'(dn0),  int'(e.done));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("w4.ready", int'(rdy1), int'(e.ready));
            check("w4.count", int'(cnt1), int'(e.count));
            check("w4.done",  int'(dn1),  int'(e.done));
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("m0.ready", int'(rdy2), int'(e.ready));
            check("m0.count", int'(cnt2), int'(e.count));
            check("m0.done",  int'(dn2),  int'(e.done));
        end
    end

    // Drive one cycle of inputs and queue the outputs expected right after the coming edge.
    task automatic step(input logic g0, input logic g1, input logic g2, input logic r,
                        input exp_t e0, input exp_t e1, input exp_t e2);
        go0 = g0;
        go1 = g1;
        go2 = g2;
        rst = r;
        q0.push_back(e0);
        q1.push_back(e1);
        q2.push_back(e2);
        @(posedge clk);
        #1;
    endtask

    // Expected outputs p cycles after acceptance: COUNT 0..maxv, then DONE, then IDLE.
    function automatic exp_t phase_exp(input int p, input int maxv);
        exp_t e;
        e = IDLE_E;
        if (p <= maxv) begin
            e.ready = 1'b0;
            e.count = 4'(p);
        end else if (p == maxv + 1) begin
            e.ready = 1'b0;
            e.done  = 1'b1;
        end
        return e;
    endfunction

    // Start from IDLE; a run can only be accepted at steps that are multiples of the period.
    task automatic run_seq(input int k, input int maxv, input logic [63:0] gom, input int n);
        int   per;
        exp_t e;
        logic g;
        per = maxv + 3;
        for (int i = 0; i < n; i++) begin
            e = gom[(i / per) * per] ? phase_exp(i % per, maxv) : IDLE_E;
            g = gom[i];
            case (k)
                0:       step(g, 1'b0, 1'b0, 1'b0, e, IDLE_E, IDLE_E);
                1:       step(1'b0, g, 1'b0, 1'b0, IDLE_E, e, IDLE_E);
                default: step(1'b0, 1'b0, g, 1'b0, IDLE_E, IDLE_E, e);
            endcase
        end
    endtask

    initial begin
        // Reset held with go high: nothing starts.
        step(1'b1, 1'b1, 1'b1, 1'b1, IDLE_E, IDLE_E, IDLE_E);
        step(1'b1, 1'b1, 1'b1, 1'b1, IDLE_E, IDLE_E, IDLE_E);
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE_E, IDLE_E, IDLE_E);

        // Single pulse: count 0..3, done, ready.
        run_seq(0, 3, 64'h1, 6);
        // Pokes during COUNT (step 2) and DONE (step 5) are ignored.
        run_seq(0, 3, 64'h25, 8);
        // go held 20 cycles: a run every 6 cycles.
        run_seq(0, 3, 64'hF_FFFF, 24);

        // Reset while count is 2: straight back to IDLE, no done.
        step(1'b1, 1'b0, 1'b0, 1'b0, phase_exp(0, 3), IDLE_E, IDLE_E);
        step(1'b0, 1'b0, 1'b0, 1'b0, phase_exp(1, 3), IDLE_E, IDLE_E);
        step(1'b0, 1'b0, 1'b0, 1'b0, phase_exp(2, 3), IDLE_E, IDLE_E);
        step(1'b0, 1'b0, 1'b0, 1'b1, IDLE_E, IDLE_E, IDLE_E);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, IDLE_E, IDLE_E, IDLE_E);

        // WIDTH=4, MAX_VAL=15: 16 count cycles, no wrap.
        run_seq(1, 15, 64'h1, 18);
        // MAX_VAL=0: done two cycles after acceptance, 3-cycle period when held.
        run_seq(2, 0, 64'h7F, 9);
        step(1'b0, 1'b0, 1'b0, 1'b0, IDLE_E, IDLE_E, IDLE_E);

        for (int i = 0; i < 10 && (q0.size() + q1.size() + q2.size()) > 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if ((q0.size() + q1.size() + q2.size()) == 0) passed++;
        else $display("FAIL drain: %0d expectations left, expected 0", q0.size() + q1.size() + q2.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
